alu_operand_fetch: RTL
======================

# alu_operand_fetch

Operand-fetch stage directly upstream of the ALU logic unit. Accepts a decoded operation (source registers, destination register, function code, optional immediate) over a valid/ready handshake and reads the 32×32 register file. It drives the registered operand pair `x`/`y` and the 3-bit `logic_function` into the ALU with a one-cycle latency. It also owns the register-file write port used by writeback, with same-cycle write-to-read bypass.

## Interface
- `DATA_W`, 32: operand and register width.
- `ADDR_W`, 5: register address width; register count is 2**ADDR_W.
- `FUNC_W`, 3: ALU function code width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  decoded operation present.
- `in_ready`  out  1  stage can accept an operation this cycle.
- `in_rs`  in  ADDR_W  source register for `x`.
- `in_rt`  in  ADDR_W  source register for `y`; ignored when `in_use_imm`=1.
- `in_rd`  in  ADDR_W  destination register, carried through.
- `in_func`  in  FUNC_W  ALU function code, carried through unchanged.
- `in_use_imm`  in  1  select `in_imm` for `y`.
- `in_imm`  in  DATA_W  immediate, already extended by decode.
- `out_valid`  out  1  `x`/`y`/`logic_function`/`out_rd` hold a valid operation.
- `out_ready`  in  1  ALU side consumes the operation this cycle.
- `x`, `y`  out  DATA_W  registered ALU operands.
- `logic_function`  out  FUNC_W  registered function code.
- `out_rd`  out  ADDR_W  registered destination register.
- `wb_en`  in  1  register-file write enable.
- `wb_addr`  in  ADDR_W  write address.
- `wb_data`  in  DATA_W  write data.

## Operation
- Register file: 2**ADDR_W × DATA_W. Register 0 reads as 0. Writes to register 0 are discarded.
- Write: when `wb_en`=1 and `wb_addr`≠0, `wb_data` is written at the clock edge.
- Read port A uses `in_rs`; read port B uses `in_rt`. Reads are combinational.
- Bypass: if `wb_en`=1, `wb_addr`≠0 and `wb_addr` equals the source register in the same cycle, the read returns `wb_data`, not the stored value. This applies to both ports independently.
- `y` source: `in_imm` when `in_use_imm`=1; otherwise port B.
- Output register stage holds one entry. `in_ready` = !`out_valid` || `out_ready` (combinational).
- Accept occurs when `in_valid` && `in_ready`. On accept, the output registers load the operands, `in_func` and `in_rd`, and `out_valid` is set to 1.
- Consume occurs when `out_valid` && `out_ready`. If there is no simultaneous accept, `out_valid` is cleared to 0.
- Simultaneous consume and accept: the new operation replaces the old one with no bubble, and `out_valid` stays 1.
- Stall (`out_valid`=1, `out_ready`=0): all outputs are held stable, and `in_ready`=0.
  - Writebacks during a stall update the register file but do not modify the held `x`/`y`.
  - RAW hazards on held operations are resolved upstream.
- Data-path registers (`x`, `y`, `logic_function`, `out_rd`) load only on accept.

## Timing
- Latency: one cycle from accept to `out_valid`=1 with the corresponding operands.
- Throughput: one operation per cycle while `out_ready`=1.
- Reset (asynchronous, on `rst_n`=0, independent of `clk`):
  - `out_valid`=0; `x`=0, `y`=0, `logic_function`=0, `out_rd`=0.
  - All registers in the file are cleared to 0.
  - `in_ready`=1 from the first cycle after release.
- Reset asserted mid-operation: any held operation is dropped. A writeback in the same cycle is lost.
- A writeback and an accept reading the same register in the same cycle: the operand captured is the new `wb_data`.

## Structure
- Shared package holds:
  - `DATA_W`, `ADDR_W` and `FUNC_W` constants.
  - A typedef for the decoded-operation bundle (rs, rt, rd, func, use_imm, imm).
  - The ALU function-code encodings, which are owned by the ALU and only passed through here.
- One sub-module: `reg_file` (two combinational read ports, one write port, asynchronous clear, register-0-zero rule).
- Bypass mux, immediate mux and the output stage live in `alu_operand_fetch`.

## Test plan
- Reset with `rst_n`=0 mid-stream: outputs go to 0 immediately. After release, reading r1/r2 gives `x`=0, `y`=0, and `in_ready`=1.
- Write r1=1 and r2=4, then issue rs=1, rt=2, func=0: the next cycle shows `x`=1, `y`=4, `logic_function`=0 and `out_valid`=1.
- Issue rs=3 with `wb_en`=1, `wb_addr`=3, `wb_data`=32'hFFFF_FFFF in the same cycle: the captured `x` is 32'hFFFF_FFFF. A write to r0 of 5 followed by rs=0 gives `x`=0.
- Immediate: rs=1 (value 1), `in_use_imm`=1, `in_imm`=5, func=3: outputs `x`=1, `y`=5, `logic_function`=3.
- Backpressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1. Outputs stay stable and `in_ready`=0 throughout. On releasing `out_ready`, the next operation loads in the same cycle with no bubble.
- Back-to-back stream of 5 operations with `out_ready`=1: 5 consecutive `out_valid` cycles arrive in order with the correct operands and `out_rd` values.

Source files
------------

// File: rtl/alu_operand_fetch_pkg.sv
// alu_operand_fetch_pkg: widths, decoded-operation bundle and pass-through ALU function codes
package alu_operand_fetch_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int FUNC_W = 3;
    localparam int NREG   = 2 ** ADDR_W;

    // Encodings belong to the ALU; this stage only carries them through
    typedef enum logic [FUNC_W-1:0] {
        FN_AND, FN_OR, FN_XOR, FN_NOR, FN_NAND, FN_XNOR, FN_ANDN, FN_ORN
    } alu_func_e;

    typedef struct packed {
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] rd;
        logic [FUNC_W-1:0] func;
        logic              use_imm;
        logic [DATA_W-1:0] imm;
    } op_t;

    function automatic logic wb_hit(logic en, logic [ADDR_W-1:0] wa, logic [ADDR_W-1:0] ra);
        return en && wa != '0 && wa == ra;
    endfunction
endpackage

// File: rtl/alu_operand_fetch_if.sv
// alu_operand_fetch_if: decoded-op input, ALU-side output and writeback port of the fetch stage
interface alu_operand_fetch_if;
    import alu_operand_fetch_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rs;
    logic [ADDR_W-1:0] in_rt;
    logic [ADDR_W-1:0] in_rd;
    logic [FUNC_W-1:0] in_func;
    logic              in_use_imm;
    logic [DATA_W-1:0] in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [FUNC_W-1:0] logic_function;
    logic [ADDR_W-1:0] out_rd;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    modport master (
        output in_valid, in_rs, in_rt, in_rd, in_func, in_use_imm, in_imm, out_ready,
               wb_en, wb_addr, wb_data,
        input  in_ready, out_valid, x, y, logic_function, out_rd
    );
    modport slave (
        input  in_valid, in_rs, in_rt, in_rd, in_func, in_use_imm, in_imm, out_ready,
               wb_en, wb_addr, wb_data,
        output in_ready, out_valid, x, y, logic_function, out_rd
    );
endinterface

// File: rtl/alu_operand_fetch_reg_file.sv
// reg_file: 2R1W register file with asynchronous clear; register 0 is hardwired to zero
module reg_file
    import alu_operand_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra_a,
    input  logic [ADDR_W-1:0] ra_b,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);
    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        else if (we && wa != '0)
            mem[wa] <= wd;
    end

    assign rd_a = ra_a == '0 ? '0 : mem[ra_a];
    assign rd_b = ra_b == '0 ? '0 : mem[ra_b];
endmodule

// File: rtl/alu_operand_fetch.sv
// alu_operand_fetch: register read with writeback bypass and a one-entry output stage feeding the ALU
module alu_operand_fetch
    import alu_operand_fetch_pkg::*;
(
    input logic                clk,
    input logic                rst_n,
    alu_operand_fetch_if.slave bus
);
    op_t               op;
    logic [DATA_W-1:0] rd_a, rd_b, opa, opb;
    logic              accept;

    assign op = '{rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd, func: bus.in_func,
                  use_imm: bus.in_use_imm, imm: bus.in_imm};

    reg_file u_rf (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (bus.wb_en),
        .wa   (bus.wb_addr),
        .wd   (bus.wb_data),
        .ra_a (op.rs),
        .ra_b (op.rt),
        .rd_a (rd_a),
        .rd_b (rd_b)
    );

    // Same-cycle writeback wins over the stored value
    assign opa = wb_hit(bus.wb_en, bus.wb_addr, op.rs) ? bus.wb_data : rd_a;
    assign opb = op.use_imm ? op.imm : wb_hit(bus.wb_en, bus.wb_addr, op.rt) ? bus.wb_data : rd_b;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid      <= 1'b0;
            bus.x              <= '0;
            bus.y              <= '0;
            bus.logic_function <= '0;
            bus.out_rd         <= '0;
        end else begin
            if (bus.in_ready) bus.out_valid <= bus.in_valid;
            if (accept) begin
                bus.x              <= opa;
                bus.y              <= opb;
                bus.logic_function <= op.func;
                bus.out_rd         <= op.rd;
            end
        end
    end
endmodule
